// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: downstream buffer for the UART receiver.
// Turns the receiver's one-sample-period ready/err levels into single-cycle
// requests, queues good bytes in a first-word-fall-through FIFO and keeps
// sticky overflow / framing-error status with a saturating error counter.
module uart_rx_fifo #(
  parameter int AddrWidth   = 4,
  parameter int ErrCntWidth = 8
) (
  input  logic                   ref_clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   rx_err,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [AddrWidth:0]     count,
  output logic                   full,
  output logic                   overflow,
  output logic                   frame_err,
  output logic [ErrCntWidth-1:0] err_count,
  input  logic                   clear_status
);

  localparam int                     Depth      = 2 ** AddrWidth;
  localparam logic [AddrWidth:0]     DepthCount = (AddrWidth + 1)'(Depth);
  localparam logic [ErrCntWidth-1:0] ErrMax     = '1;

  logic [7:0]           mem [Depth];
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic                 rx_ready_d;
  logic                 rx_err_d;

  logic push_req;
  logic err_req;
  logic pop;
  logic push_ok;

  // Rising edges of the receiver levels; a held level yields one request.
  assign push_req = rx_ready & ~rx_ready_d;
  assign err_req  = rx_err & ~rx_err_d;

  assign out_valid = (count != '0);
  assign full      = (count == DepthCount);
  assign pop       = out_valid & out_ack;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok   = push_req & (~full | pop);

  // Head of queue is shown combinationally (first-word fall-through).
  assign out_data = mem[rd_ptr];

  // Edge-detect history; resets high so a level still up after reset is ignored.
  always_ff @(posedge ref_clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      rx_ready_d <= 1'b1;
      rx_err_d   <= 1'b1;
    end else begin
      rx_ready_d <= rx_ready;
      rx_err_d   <= rx_err;
    end
  end

  // Storage array write port.
  always_ff @(posedge ref_clk) begin
    // NOTE: the array has no reset; occupancy lives in count, so stale
    // entries are never observed and the array can map onto plain RAM.
    if (push_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AddrWidth'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AddrWidth'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AddrWidth + 1)'(1);
        2'b01:   count <= count - (AddrWidth + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status; clear_status beats any same-cycle set or increment.
  always_ff @(posedge ref_clk) begin
    if (reset || clear_status) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
      if (err_req) begin
        frame_err <= 1'b1;
        if (err_count != ErrMax) begin
          err_count <= err_count + ErrCntWidth'(1);
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Downstream buffer for the UART receiver. Edge-detects the receiver's per-frame ready/err level outputs, which are held for one sample period. Each completed byte is pushed into a first-word-fall-through FIFO, and the byte is presented to the consumer with a valid/ack handshake. Keeps sticky overflow and framing-error flags plus a saturating framing-error counter for status readback.

Parameters:
AddrWidth, 4, log2 of FIFO depth; depth = 2**AddrWidth entries of 8 bits.
ErrCntWidth, 8, width of saturating framing-error counter.

Ports:
ref_clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  byte from receiver, stored and presented bit-for-bit unchanged.
rx_ready  input  1  receiver frame-complete level; high for one sample period per good frame.
rx_err  input  1  receiver framing-error level; high for one sample period per bad frame.
out_data  output  8  head-of-FIFO byte; valid only while out_valid.
out_valid  output  1  FIFO non-empty.
out_ack  input  1  consumer pops head when out_valid && out_ack.
count  output  AddrWidth+1  current occupancy, 0..2**AddrWidth.
full  output  1  count == 2**AddrWidth.
overflow  output  1  sticky: a byte was dropped because FIFO was full.
frame_err  output  1  sticky: at least one framing error seen.
err_count  output  ErrCntWidth  saturating count of framing errors.
clear_status  input  1  clears overflow, frame_err, err_count.

Behaviour:
- Reset (synchronous, active-high, ref_clk):
  - count=0; out_valid=0; full=0; overflow=0; frame_err=0; err_count=0.
  - out_data is don't-care while out_valid=0.
  - Read/write pointers go to 0.
  - Edge-detect registers rx_ready_d and rx_err_d reset to 1, so a level still high from a frame completed during reset does not produce a capture.
- Edge detect:
  - push_req = rx_ready && !rx_ready_d.
  - err_req = rx_err && !rx_err_d.
  - Both _d registers sample their inputs every cycle. A held-high level therefore yields exactly one request.
- Push: on push_req, if count < depth or a pop occurs in the same cycle:
  - write rx_data at wr_ptr;
  - wr_ptr+1, wrapping modulo depth.
- Pop: on out_valid && out_ack:
  - rd_ptr+1, wrapping modulo depth.
  - out_ack while out_valid=0 is ignored. No pointer or count change.
- Count update: count += push_accepted - pop. Simultaneous push and pop leaves count unchanged.
- Latency: push_req in cycle N (FIFO empty) -> out_valid=1 and out_data=byte in cycle N+1. out_data always reflects mem[rd_ptr] (FWFT).
- Full: push_req with count==depth and no pop in the same cycle:
  - byte dropped; FIFO contents unchanged;
  - overflow set to 1.
  - With a simultaneous pop, the push is accepted and overflow is not set.
- Framing error: on err_req:
  - frame_err set to 1;
  - err_count increments, saturating at 2**ErrCntWidth-1 (no wrap);
  - no FIFO write.
- push_req and err_req are never asserted together by a well-formed receiver. If both occur, the push is processed and the error is also recorded.
- clear_status: clears overflow, frame_err and err_count next cycle. It has priority over a same-cycle set or increment (cleared value wins). FIFO contents are untouched.
- Reset mid-operation: FIFO flushed, all status cleared. A byte whose ready level straddles reset deassertion is discarded.
- Pointers are AddrWidth bits. count is held as a separate AddrWidth+1 register. full and out_valid are decoded from count.

Test Plan:
- Single byte: reset; rx_data=0xA5, rx_ready high 16 cycles -> exactly one push; cycle after the edge, out_valid=1, out_data=0xA5, count=1. out_ack 1 cycle -> out_valid=0, count=0.
- Ordering/wrap (AddrWidth=4): push 0x00..0x1F with pops interleaved so count never exceeds 10 -> bytes emerge in order 0x00..0x1F, pointers wrap twice, overflow=0.
- Overflow: push 17 bytes 0x10..0x20 with no acks -> full=1, count=16, overflow=1; drain yields 0x10..0x1F, 0x20 absent. Repeat at full with out_ack in the push cycle -> push accepted, count stays 16, overflow not set.
- Framing errors: 3 rx_err pulses -> frame_err=1, err_count=3, count unchanged. With ErrCntWidth=2, 5 pulses -> err_count=3 (saturated). clear_status -> all zero.
- Reset straddle: assert reset while rx_ready=1, release with rx_ready still 1 -> no push, count=0. Next fresh rx_ready rise with 0x3C -> out_data=0x3C.
- Clear vs set: clear_status in the same cycle as err_req -> err_count=0, frame_err=0 afterwards.
